// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - triggered single-frame capture into sample RAM with valid/ack hold
// Optional feature macro: AUTO_REARM_EN (continuous re-arm after Frame_ack).
module capture_sequencer #(
  parameter int DW           = 8,
  parameter int AW           = 8,
  parameter int DEPTH        = 256,
  parameter int TRIG_TIMEOUT = 4095
) (
  input  logic          Fg_CLK,
  input  logic          RESET,
  input  logic          Ready,
  input  logic          Enable,
  input  logic [3:0]    Mode,
  input  logic          Arm,
  input  logic [DW-1:0] Sample_in,
  input  logic [DW-1:0] Trig_level,
  output logic          Wr_en,
  output logic [AW-1:0] Wr_addr,
  output logic [DW-1:0] Wr_data,
  output logic          Frame_valid,
  input  logic          Frame_ack,
  output logic [3:0]    Frame_mode,
  output logic          Busy,
  output logic          Forced
);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_IDLE,
    ST_WAIT_TRIG,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  localparam int            TW        = (TRIG_TIMEOUT > 1) ? $clog2(TRIG_TIMEOUT + 1) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_t          state_q, state_d;
  logic [DW-1:0]   prev_q, prev_d;
  logic            first_q, first_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wr_en_d;
  logic [AW-1:0]   wr_addr_d;
  logic [DW-1:0]   wr_data_d;
  logic            fvalid_d;
  logic [3:0]      fmode_d;
  logic            forced_d;
  logic            busy_d;
  logic            trig;
  logic            timeout;
  logic            go_wait;
`ifdef AUTO_REARM_EN
  logic            arm_low_q, arm_low_d;
`endif

  always_ff @(posedge Fg_CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_STARTUP;
      prev_q      <= '0;
      first_q     <= 1'b0;
      tcnt_q      <= '0;
      addr_q      <= '0;
      Wr_en       <= 1'b0;
      Wr_addr     <= '0;
      Wr_data     <= '0;
      Frame_valid <= 1'b0;
      Frame_mode  <= '0;
      Busy        <= 1'b0;
      Forced      <= 1'b0;
`ifdef AUTO_REARM_EN
      arm_low_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      first_q     <= first_d;
      tcnt_q      <= tcnt_d;
      addr_q      <= addr_d;
      Wr_en       <= wr_en_d;
      Wr_addr     <= wr_addr_d;
      Wr_data     <= wr_data_d;
      Frame_valid <= fvalid_d;
      Frame_mode  <= fmode_d;
      Busy        <= busy_d;
      Forced      <= forced_d;
`ifdef AUTO_REARM_EN
      arm_low_q   <= arm_low_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    first_d   = first_q;
    tcnt_d    = tcnt_q;
    addr_d    = addr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = Wr_addr;
    wr_data_d = Wr_data;
    fvalid_d  = Frame_valid;
    fmode_d   = Frame_mode;
    forced_d  = Forced;
    trig      = 1'b0;
    timeout   = 1'b0;
    go_wait   = 1'b0;
`ifdef AUTO_REARM_EN
    arm_low_d = arm_low_q;
`endif

    case (state_q)
      ST_STARTUP: begin
        if (Ready) state_d = ST_IDLE;
      end

      ST_IDLE: begin
        if (Arm) begin
          state_d = ST_WAIT_TRIG;
          first_d = 1'b1;
          tcnt_d  = '0;
        end
      end

      ST_WAIT_TRIG: begin
        if (!Arm) begin
          state_d = ST_IDLE;
        end else if (Enable) begin
          prev_d = Sample_in;
          // The first strobe only seeds the edge detector.
          if (first_q) begin
            first_d = 1'b0;
          end else begin
            trig    = (prev_q < Trig_level) && (Sample_in >= Trig_level);
            timeout = !trig && (TRIG_TIMEOUT != 0) &&
                      ((32'(tcnt_q) + 32'd1) == 32'(TRIG_TIMEOUT));
            if (!trig) tcnt_d = tcnt_q + TW'(1);
            if (trig || timeout) begin
              wr_en_d   = 1'b1;
              wr_addr_d = '0;
              wr_data_d = Sample_in;
              addr_d    = AW'(1);
              fmode_d   = Mode;
              forced_d  = timeout;
              state_d   = ST_CAPTURE;
            end
          end
        end
      end

      ST_CAPTURE: begin
        if (Mode != Frame_mode) begin
          state_d = ST_IDLE;
        end else if (Enable) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = Sample_in;
          addr_d    = addr_q + AW'(1);
          if (addr_q == LAST_ADDR) begin
            state_d = ST_HOLD;
`ifdef AUTO_REARM_EN
            arm_low_d = 1'b1;
`endif
          end
        end
      end

      ST_HOLD: begin
`ifdef AUTO_REARM_EN
        arm_low_d = arm_low_q & ~Arm;
        go_wait   = Arm | ~arm_low_q;
`else
        go_wait   = Arm;
`endif
        // Frame_valid rises one cycle after the final write; ack only counts once it is up.
        if (Frame_valid && Frame_ack) begin
          fvalid_d = 1'b0;
          if (go_wait) begin
            state_d = ST_WAIT_TRIG;
            first_d = 1'b1;
            tcnt_d  = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          fvalid_d = 1'b1;
        end
      end

      default: state_d = ST_STARTUP;
    endcase

    busy_d = (state_d == ST_WAIT_TRIG) || (state_d == ST_CAPTURE);
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - randomized self-checking bench for capture_sequencer
module tb_capture_sequencer;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 4;
  localparam int TT    = 5;

  typedef logic [DW-1:0] sq_t[$];

  logic          Fg_CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          Ready = 1'b0;
  logic          Enable = 1'b0;
  logic [3:0]    Mode = '0;
  logic          Arm = 1'b0;
  logic [DW-1:0] Sample_in = '0;
  logic [DW-1:0] Trig_level = '0;
  logic          Frame_ack = 1'b0;
  logic          Wr_en;
  logic [AW-1:0] Wr_addr;
  logic [DW-1:0] Wr_data;
  logic          Frame_valid;
  logic [3:0]    Frame_mode;
  logic          Busy;
  logic          Forced;

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] wa_q[$];
  logic [DW-1:0] wd_q[$];

  always #5 Fg_CLK = ~Fg_CLK;

  capture_sequencer #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .TRIG_TIMEOUT(TT)) dut (
    .Fg_CLK(Fg_CLK), .RESET(RESET), .Ready(Ready), .Enable(Enable), .Mode(Mode),
    .Arm(Arm), .Sample_in(Sample_in), .Trig_level(Trig_level), .Wr_en(Wr_en),
    .Wr_addr(Wr_addr), .Wr_data(Wr_data), .Frame_valid(Frame_valid),
    .Frame_ack(Frame_ack), .Frame_mode(Frame_mode), .Busy(Busy), .Forced(Forced)
  );

  always @(negedge Fg_CLK) begin
    if (Wr_en) begin
      wa_q.push_back(Wr_addr);
      wd_q.push_back(Wr_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Fg_CLK);
    #1;
  endtask

  task automatic strobe(input logic [DW-1:0] s);
    Sample_in = s;
    Enable = 1'b1;
    tick();
    Enable = 1'b0;
  endtask

  // Strobe index at which the frame starts, from the edge/timeout rules.
  function automatic int trig_index(input sq_t s, input logic [DW-1:0] lvl, output bit forced);
    forced = 1'b0;
    for (int k = 1; k < s.size(); k++) begin
      if (s[k-1] < lvl && s[k] >= lvl) return k;
      if (k == TT) begin
        forced = 1'b1;
        return k;
      end
    end
    return -1;
  endfunction

  task automatic run_frame(input sq_t s, input logic [3:0] mode, input logic [DW-1:0] lvl,
                           input bit arm_after, input bit ack_en);
    int  t;
    int  last;
    bit  f;
    wa_q.delete();
    wd_q.delete();
    Mode = mode;
    Trig_level = lvl;
    Arm = 1'b1;
    tick();
    tick();
    t = trig_index(s, lvl, f);
    last = t + DEPTH - 1;
    for (int k = 0; k < s.size(); k++) begin
      strobe(s[k]);
      if (k < last) chk("busy_run", 32'(Busy), 32'd1);
      if (k == last) begin
        chk("fv_early", 32'(Frame_valid), 32'd0);
        tick();
        chk("fv_next", 32'(Frame_valid), 32'd1);
      end else if ($urandom_range(1, 0) == 1) begin
        tick();
      end
    end
    tick();
    chk("fv_hold", 32'(Frame_valid), 32'd1);
    chk("busy_hold", 32'(Busy), 32'd0);
    chk("forced", 32'(Forced), 32'(f));
    chk("frame_mode", 32'(Frame_mode), 32'(mode));
    chk("wr_count", 32'(wa_q.size()), 32'(DEPTH));
    for (int i = 0; i < DEPTH && i < wa_q.size(); i++) begin
      chk("wr_addr", 32'(wa_q[i]), 32'(i));
      chk("wr_data", 32'(wd_q[i]), 32'(s[t+i]));
    end
    Arm = arm_after;
    Frame_ack = 1'b1;
    Enable = ack_en;
    Sample_in = 8'($urandom_range(255, 0));
    tick();
    Frame_ack = 1'b0;
    Enable = 1'b0;
    chk("fv_ack", 32'(Frame_valid), 32'd0);
    chk("busy_ack", 32'(Busy), 32'(arm_after));
  endtask

  initial begin
    sq_t s;

    tick();
    chk("rst_wr_en", 32'(Wr_en), 32'd0);
    chk("rst_wr_addr", 32'(Wr_addr), 32'd0);
    chk("rst_wr_data", 32'(Wr_data), 32'd0);
    chk("rst_fv", 32'(Frame_valid), 32'd0);
    chk("rst_fmode", 32'(Frame_mode), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_forced", 32'(Forced), 32'd0);
    RESET = 1'b0;

    // Startup: Arm without Ready does nothing.
    wa_q.delete();
    Arm = 1'b1;
    Trig_level = 8'h80;
    repeat (6) strobe(8'($urandom_range(255, 0)));
    chk("startup_busy", 32'(Busy), 32'd0);
    chk("startup_writes", 32'(wa_q.size()), 32'd0);
    Ready = 1'b1;
    tick();
    Ready = 1'b0;
    chk("ready_idle", 32'(Busy), 32'd0);
    tick();
    chk("ready_wait", 32'(Busy), 32'd1);

    s = '{8'h10, 8'h7F, 8'h80, 8'h81, 8'h05, 8'hFF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_frame(s, 4'd3, 8'h80, 1'b0, 1'b0);

    s = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    run_frame(s, 4'd1, 8'h80, 1'b1, 1'b1);

    // Arm dropped while waiting for trigger.
    Arm = 1'b1;
    tick();
    tick();
    chk("wait_busy", 32'(Busy), 32'd1);
    Arm = 1'b0;
    tick();
    chk("disarm_busy", 32'(Busy), 32'd0);

    // Abort on mode change mid-frame.
    wa_q.delete();
    Mode = 4'd1;
    Trig_level = 8'h80;
    Arm = 1'b1;
    tick();
    tick();
    strobe(8'h10);
    strobe(8'h90);
    strobe(8'h91);
    Mode = 4'd2;
    Arm = 1'b0;
    tick();
    chk("abort_busy", 32'(Busy), 32'd0);
    repeat (4) strobe(8'($urandom_range(255, 0)));
    tick();
    chk("abort_writes", 32'(wa_q.size()), 32'd2);
    chk("abort_fv", 32'(Frame_valid), 32'd0);

    // Asynchronous reset in the middle of a frame.
    Mode = 4'd1;
    Arm = 1'b1;
    tick();
    tick();
    strobe(8'h10);
    strobe(8'h90);
    strobe(8'h91);
    #2 RESET = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(Wr_en), 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    chk("mid_rst_fmode", 32'(Frame_mode), 32'd0);
    chk("mid_rst_wr_addr", 32'(Wr_addr), 32'd0);
    tick();
    RESET = 1'b0;
    wa_q.delete();
    repeat (8) strobe(8'($urandom_range(255, 0)));
    chk("post_rst_busy", 32'(Busy), 32'd0);
    chk("post_rst_writes", 32'(wa_q.size()), 32'd0);
    Ready = 1'b1;
    tick();
    Ready = 1'b0;

    for (int n = 0; n < 20; n++) begin
      s.delete();
      for (int k = 0; k < 12; k++) s.push_back(8'($urandom_range(255, 0)));
      run_frame(s, 4'($urandom_range(4, 0)), 8'($urandom_range(200, 40)),
                1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
Sequences waveform capture for the DDS scope path. Consumes the sample strobe, startup pulse and decimation mode from the sampling controller. Waits for an arm request and a rising-edge trigger, then writes one frame of DEPTH samples into the external sample RAM. It then holds the frame for the readout/display engine under a valid/ack handshake.

Parameters:
DW, 8, sample width in bits
AW, 8, RAM address width
DEPTH, 256, samples per frame (2..2**AW)
TRIG_TIMEOUT, 4095, sample strobes to wait for trigger before forced capture (0 = wait forever)

Ports:
Fg_CLK  in  1  system clock
RESET  in  1  asynchronous reset, active-high
Ready  in  1  one-cycle startup pulse from sampling controller
Enable  in  1  sample strobe, one cycle wide
Mode  in  4  current decimation mode (0-4)
Arm  in  1  level request to capture one frame
Sample_in  in  DW  unsigned sample, valid when Enable=1
Trig_level  in  DW  unsigned trigger threshold
Wr_en  out  1  RAM write strobe
Wr_addr  out  AW  RAM write address
Wr_data  out  DW  RAM write data
Frame_valid  out  1  frame complete and stable in RAM
Frame_ack  in  1  readout finished with frame
Frame_mode  out  4  Mode latched at trigger
Busy  out  1  high in WAIT_TRIG or CAPTURE
Forced  out  1  frame started by timeout, not trigger

Behaviour:
- Reset: state=STARTUP; Wr_en=0, Wr_addr=0, Wr_data=0, Frame_valid=0, Frame_mode=0, Busy=0, Forced=0; prev sample=0; timeout count=0.
- Only Enable cycles do work; all other cycles hold state except where noted.
- STARTUP: ignores all inputs until Ready=1, then goes to IDLE next cycle. Ready arriving in any later state is ignored.
- IDLE: on Arm=1, goes to WAIT_TRIG. Clears the timeout count and sets prev sample to the first Sample_in seen in WAIT_TRIG; no trigger is possible on that first strobe.
- WAIT_TRIG, per Enable:
  - Trigger = prev<Trig_level && Sample_in>=Trig_level (unsigned compare); then prev<=Sample_in.
  - On trigger: that sample is written at addr 0 in the same cycle's registered write, Frame_mode<=Mode, Forced<=0, next state CAPTURE.
  - Else timeout count increments. When TRIG_TIMEOUT!=0 and the count reaches TRIG_TIMEOUT, the current sample is written as for a trigger with Forced<=1.
- CAPTURE: each Enable writes Sample_in at the next address. The write is registered, so Wr_en/Wr_addr/Wr_data are valid one cycle after the Enable and Wr_en is a 1-cycle pulse. After the write at address DEPTH-1, state goes to HOLD and Frame_valid=1 in the cycle after that last Wr_en. Wr_addr does not wrap inside a frame.
- HOLD: Frame_valid=1, no writes. Frame_ack=1 clears Frame_valid the next cycle and returns to IDLE, or to WAIT_TRIG if Arm is still 1. Frame_ack outside HOLD is ignored.
- Mode change (Mode != Frame_mode) during CAPTURE aborts: no further writes, Busy=0, state goes to IDLE, Frame_valid stays 0.
- Arm deasserted during WAIT_TRIG returns to IDLE. Arm is ignored during CAPTURE.
- Enable and Frame_ack in the same cycle in HOLD: the ack wins and the sample is discarded.
- Busy = state is WAIT_TRIG or CAPTURE, registered.
- Asynchronous RESET mid-frame drops everything immediately; the RAM contents are don't-care.

Optional Feature:
AUTO_REARM_EN
- Defined: after Frame_ack the block re-enters WAIT_TRIG regardless of Arm, giving continuous triggered capture. Arm=0 sampled in HOLD at ack time still returns to IDLE only if Arm has been low for the whole HOLD period.
- Undefined: behaviour exactly as above; Arm level decides.

Test Plan:
- Startup: Arm=1 with no Ready -> Busy stays 0, no Wr_en. Ready pulse -> WAIT_TRIG on the following cycle.
- Trigger: Trig_level=0x80, strobe samples 0x10,0x7F,0x80,... -> first Wr_en at addr 0 with data 0x80, Forced=0, Frame_mode=Mode.
- Full frame, DEPTH=4: 4 strobes after trigger -> Wr_addr 0..3, Frame_valid=1 the cycle after the addr-3 write. Frame_ack -> Frame_valid=0 next cycle, then IDLE (Arm=0) or WAIT_TRIG (Arm=1).
- Timeout: TRIG_TIMEOUT=5, constant sample 0x20 below level -> write on 5th strobe after first, Forced=1.
- Abort: Mode 1->2 after 2 of 4 writes -> no further Wr_en, Frame_valid stays 0, Busy=0.
- Reset mid-CAPTURE: RESET pulse -> all outputs 0 immediately; no capture until a new Ready pulse.
